// File: rtl/lut_eval_seq.sv
// Run-time programmable truth-table evaluator: single lookups over a
// valid/ready stream, or an autonomous sweep of indices 0..sweep_last.
module lut_eval_seq #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IN_W-1:0]  cfg_addr,
  input  logic [OUT_W-1:0] cfg_data,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             sweep_start,
  input  logic [IN_W-1:0]  sweep_last,
  output logic             sweep_done,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IN_W-1:0]  out_index
);

  localparam int unsigned DEPTH = 1 << IN_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_d;

  logic [OUT_W-1:0] tbl [DEPTH];

  logic [IN_W-1:0] cnt, cnt_d;
  logic [IN_W-1:0] last_r, last_d;
  logic            slot_free_c;
  logic            accept_c;
  logic            wr_c;
  logic            load_c;
  logic [IN_W-1:0] load_idx_c;
  logic            sweep_done_d;

  // Output slot may be refilled when empty or being drained this cycle.
  assign slot_free_c = ~out_valid | out_ready;

  // Lookups only in IDLE; a concurrent sweep_start takes priority.
  assign in_ready = (state == S_IDLE) & ~sweep_start & slot_free_c;
  assign accept_c = in_valid & in_ready;

  // Table writes are only honoured in IDLE.
  assign wr_c = cfg_we & (state == S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, sweep counter control and output-slot load selection.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    last_d       = last_r;
    load_c       = 1'b0;
    load_idx_c   = in_data;
    sweep_done_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (sweep_start) begin
          state_d = S_SWEEP;
          last_d  = sweep_last;
          cnt_d   = '0;
        end else if (accept_c) begin
          load_c     = 1'b1;
          load_idx_c = in_data;
        end
      end
      S_SWEEP: begin
        if (slot_free_c) begin
          load_c     = 1'b1;
          load_idx_c = cnt;
          // Stop at last_r so the counter never wraps.
          if (cnt == last_r) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt + IN_W'(1);
          end
        end
      end
      S_DONE: begin
        // Wait for the final sweep result to leave the slot.
        if (slot_free_c) begin
          state_d      = S_IDLE;
          sweep_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sweep index counter and latched end index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      last_r <= '0;
    end else begin
      cnt    <= cnt_d;
      last_r <= last_d;
    end
  end

  // Truth table; read before write gives old data on a same-cycle hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl <= '{default: '0};
    end else if (wr_c) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // Output register slot: holds while out_valid & ~out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else if (load_c) begin
      out_valid <= 1'b1;
      out_data  <= tbl[load_idx_c];
      out_index <= load_idx_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Status pulses and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err    <= 1'b0;
      sweep_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cfg_err    <= cfg_we & (state != S_IDLE);
      sweep_done <= sweep_done_d;
      busy       <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_lut_eval_seq.sv
// Directed bench for lut_eval_seq with an expected-result scoreboard.
module tb_lut_eval_seq;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned OUT_W = 3;
  localparam int unsigned EW    = IN_W + OUT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [IN_W-1:0]  cfg_addr;
  logic [OUT_W-1:0] cfg_data;
  logic             cfg_err;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             sweep_start;
  logic [IN_W-1:0]  sweep_last;
  logic             sweep_done;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [IN_W-1:0]  out_index;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int pops   = 0;

  logic [EW-1:0]    sb [$];
  logic [OUT_W-1:0] model [16];

  lut_eval_seq #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sweep_start(sweep_start), .sweep_last(sweep_last), .sweep_done(sweep_done),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] fn(input logic [3:0] k);
    logic x;
    x = k[1] ^ k[0];
    return {x, ~x, k[0]};
  endfunction

  task automatic push(input logic [IN_W-1:0] idx);
    sb.push_back({idx, model[idx]});
  endtask

  // Compare every accepted output against the head of the scoreboard.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_index", 32'(out_index), 32'(e[EW-1:OUT_W]));
        chk("sb_data",  32'(out_data),  32'(e[OUT_W-1:0]));
        pops++;
      end
    end
  end

  initial begin
    int done_at;
    int ndone;
    bit found;
    int pops0;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; sweep_start = 1'b0; sweep_last = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) model[k] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_data",   32'(out_data),   32'd0);
    chk("rst_out_index",  32'(out_index),  32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_cfg_err",    32'(cfg_err),    32'd0);
    chk("rst_sweep_done", 32'(sweep_done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Unprogrammed lookup
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'd7; push(4'd7);
    tick();
    in_valid = 1'b0;
    chk("lk7_valid", 32'(out_valid), 32'd1);
    chk("lk7_data",  32'(out_data),  32'd0);
    chk("lk7_index", 32'(out_index), 32'd7);
    tick();

    // Program the table
    for (int k = 0; k < 16; k++) begin
      cfg_we = 1'b1; cfg_addr = 4'(k); cfg_data = fn(4'(k));
      model[k] = fn(4'(k));
      tick();
    end
    cfg_we = 1'b0;

    // Back-to-back lookups 5, 6, 3
    in_valid = 1'b1; in_data = 4'd5; push(4'd5);
    tick();
    chk("lk5_data", 32'(out_data), 32'h5);
    chk("lk5_index", 32'(out_index), 32'd5);
    in_data = 4'd6; push(4'd6);
    tick();
    chk("lk6_data", 32'(out_data), 32'h4);
    chk("lk6_index", 32'(out_index), 32'd6);
    in_data = 4'd3; push(4'd3);
    tick();
    chk("lk3_data", 32'(out_data), 32'h3);
    chk("lk3_index", 32'(out_index), 32'd3);
    in_valid = 1'b0;
    tick();

    // Free-running sweep 0..9
    sweep_start = 1'b1; sweep_last = 4'd9;
    for (int k = 0; k <= 9; k++) push(4'(k));
    tick();
    sweep_start = 1'b0;
    done_at = 0; ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (sweep_done) begin
        ndone++;
        if (done_at == 0) done_at = i;
      end
      if (i <= 10) begin
        chk("sw9_busy", 32'(busy), 32'd1);
        chk("sw9_in_ready", 32'(in_ready), 32'd0);
      end
    end
    chk("sw9_done_count", 32'(ndone), 32'd1);
    chk("sw9_done_cycle", 32'(done_at), 32'd11);
    chk("sw9_sb_empty", 32'(sb.size()), 32'd0);
    chk("sw9_busy_end", 32'(busy), 32'd0);

    // Sweep with a 5-cycle stall at index 2 and a rejected config write
    sweep_start = 1'b1; sweep_last = 4'd4;
    for (int k = 0; k <= 4; k++) push(4'(k));
    tick();
    sweep_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid && out_index == 4'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("stall_reach_idx2", 32'(found), 32'd1);
    out_ready = 1'b0;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 3'b111;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data",  32'(out_data),  32'h4);
      chk("stall_index", 32'(out_index), 32'd2);
      if (s == 0) begin
        chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
        cfg_we = 1'b0;
      end
      if (s == 1) chk("cfg_err_clear", 32'(cfg_err), 32'd0);
    end
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sweep_done) begin
        found = 1'b1;
        break;
      end
    end
    chk("stall_done_seen", 32'(found), 32'd1);
    chk("stall_sb_empty", 32'(sb.size()), 32'd0);
    tick();
    in_valid = 1'b1; in_data = 4'd0; push(4'd0);
    tick();
    in_valid = 1'b0;
    chk("tbl0_unchanged", 32'(out_data), 32'h2);
    tick();

    // Same-cycle write and lookup of entry 4
    cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 3'b111;
    in_valid = 1'b1; in_data = 4'd4; push(4'd4);
    model[4] = 3'b111;
    tick();
    cfg_we = 1'b0;
    chk("rw_old_data", 32'(out_data), 32'h2);
    push(4'd4);
    tick();
    in_valid = 1'b0;
    chk("rw_new_data", 32'(out_data), 32'h7);
    tick();

    // Reset in the middle of a full sweep
    sweep_start = 1'b1; sweep_last = 4'd15;
    for (int k = 0; k <= 15; k++) push(4'(k));
    tick();
    sweep_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid && out_index == 4'd6) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_reach_idx6", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_index", 32'(out_index), 32'd0);
    sb.delete();
    for (int k = 0; k < 16; k++) model[k] = '0;
    tick();
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 4'd5; push(4'd5);
    tick();
    in_valid = 1'b0;
    chk("post_rst_lk5", 32'(out_data), 32'h0);
    tick();

    // Single-entry sweep
    pops0 = pops;
    sweep_start = 1'b1; sweep_last = 4'd0; push(4'd0);
    tick();
    sweep_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sweep_done) begin
        found = 1'b1;
        break;
      end
    end
    chk("sw0_done_seen", 32'(found), 32'd1);
    chk("sw0_one_result", 32'(pops - pops0), 32'd1);
    chk("sw0_sb_empty", 32'(sb.size()), 32'd0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lut_eval_seq.md
Name: lut_eval_seq

Overview:
- Parametrised, clocked truth-table evaluator: a run-time programmable lookup table of 2^IN_W entries, each OUT_W bits wide.
- Successor to the fixed combinational 4-in/3-out minimization block: any function of IN_W inputs is loaded through a config port instead of being hard-coded.
- Two evaluation modes:
  - single lookups over a valid/ready stream;
  - an autonomous sweep that enumerates inputs 0..sweep_last, replacing bench-side enumeration loops.

Parameters:
IN_W, 4, number of function inputs; table depth = 2^IN_W
OUT_W, 3, number of function outputs per entry

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  table write strobe
cfg_addr  input  IN_W  table entry to write
cfg_data  input  OUT_W  value written to table[cfg_addr]
cfg_err  output  1  one-cycle pulse: cfg_we rejected (not IDLE)
in_valid  input  1  lookup request valid
in_ready  output  1  lookup request accepted when in_valid & in_ready
in_data  input  IN_W  input vector to evaluate
sweep_start  input  1  start sweep (pulse)
sweep_last  input  IN_W  last index of sweep, sampled with sweep_start
sweep_done  output  1  one-cycle pulse after last sweep result accepted
busy  output  1  high when FSM not IDLE
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  OUT_W  table[index]
out_index  output  IN_W  input vector that produced out_data

Behaviour:
- Reset (async, rst_n=0): all table entries 0; FSM=IDLE; out_valid=0, out_data=0, out_index=0, cfg_err=0, sweep_done=0, busy=0.
- Reset may assert at any time, including mid-sweep. On release, the block is in IDLE and the table must be reprogrammed.
- Output register slot is free when ~out_valid | out_ready (same-cycle drain and refill permitted).
- Slot rule: out_valid, out_data and out_index hold stable while out_valid & ~out_ready.
- Config:
  - In IDLE, cfg_we writes table[cfg_addr] <= cfg_data at the next edge.
  - cfg_we outside IDLE is ignored, and cfg_err=1 for the following cycle.
- Single lookup:
  - in_ready = IDLE & ~sweep_start & slot free (combinational).
  - On accept: out_data <= table[in_data], out_index <= in_data, out_valid <= 1. Latency 1 cycle, throughput 1/cycle when out_ready=1.
  - Same-cycle accept and cfg write to the same address: lookup returns the old entry; the write takes effect afterwards.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on sweep_start. Latch sweep_last to last_r and clear index counter cnt=0. Concurrent in_valid is not accepted.
  - SWEEP: each cycle the slot is free, load out_data <= table[cnt], out_index <= cnt, out_valid <= 1.
    - If cnt==last_r, go to DONE; else cnt <= cnt+1.
    - cnt never wraps past 2^IN_W-1.
  - DONE: remain until the last result is accepted (out_valid & out_ready, or out_valid already 0). Then sweep_done=1 for one cycle and return to IDLE.
  - sweep_last=0 produces exactly one result (index 0).
  - sweep_last=2^IN_W-1 produces all 2^IN_W results, in order, with no gaps when out_ready=1.
  - sweep_start outside IDLE is ignored.
- busy = (state != IDLE).
- Widths: cnt and out_index are IN_W bits. No arithmetic beyond the cnt increment.

Test Plan:
- Reset, then lookup in_data=4'd7 without programming -> one cycle later out_valid=1, out_data=3'b000, out_index=4'd7.
- Program all 16 entries with table[k]={k[1]^k[0], ~(k[1]^k[0]), k[0]}, then lookups 5, 6, 3 back-to-back with out_ready=1 -> out_data 3'b101, 3'b100, 3'b011 on consecutive cycles, out_index 5, 6, 3.
- Same table, sweep_start with sweep_last=4'd9 and out_ready=1 -> 10 results, index 0..9, data 010,101,100,011,010,101,100,011,010,101. sweep_done pulses once, one cycle after the index-9 accept. busy=1 throughout. in_ready=0 during sweep.
- Sweep with out_ready held 0 for 5 cycles at index 2 -> out_data/out_index stable at 3'b100/2. No index skipped or duplicated after release. cfg_we asserted during the sweep -> cfg_err pulse, table unchanged (verified by a later lookup).
- Same cycle in IDLE: cfg_we addr=4 data=3'b111 and lookup in_data=4 -> result 3'b010 (old value). A following lookup of 4 -> 3'b111.
- Assert rst_n=0 mid-sweep at index 6 -> out_valid=0 and busy=0 immediately. After release, a lookup of 5 -> 3'b000 (table cleared). sweep_last=0 sweep -> single result, index 0, then sweep_done.
